// File: rtl/clk_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_switch_pkg
// Description : Shared types and default constants for the clock-switch
//               sequencer and its round-robin arbiter.
// Contents    : sw_state_t      - sequencer state encoding
//               DRAIN_CYC_DEF   - default drain length (cycles)
//               SETTLE_CYC_DEF  - default settle length (cycles)
//               CW_DEF          - default sequence-counter width
// Revision    : 1.0 - initial release
// ============================================================================
package clk_switch_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        SWITCH = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } sw_state_t;

    localparam int DRAIN_CYC_DEF  = 2;
    localparam int SETTLE_CYC_DEF = 4;
    localparam int CW_DEF         = 4;

endpackage
`default_nettype wire

// File: rtl/clk_switch_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter. The grant is combinational
//               so the parent can register it together with the selected
//               data; the priority pointer is registered.
// Ports       : clkAB  in  clock
//               rst    in  synchronous active-high reset
//               req    in  [1:0] requests, bit i = requester i
//               enable in  arbitration allowed this cycle
//               gnt    out [1:0] one-hot grant (combinational)
//               ptr    out requester favoured on a tie (0 or 1)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import clk_switch_pkg::*;
(
    input  logic       clkAB,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt,
    output logic       ptr
);

    logic       r_ptr;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    // After any grant, favour the requester that was not just served.
    always_ff @(posedge clkAB) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (|w_gnt) begin
            r_ptr <= w_gnt[0];
        end
    end

    assign gnt = w_gnt;
    assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_switch_ctrl
// Description : Drain/switch/settle sequencer owning the AB/CD clock selects,
//               plus round-robin sharing of the 2-bit capture input di.
//               Capture is stalled around every select change.
// Ports       : clkAB   in  muxed A/B clock
//               rst     in  synchronous active-high reset
//               sw_req  in  switch request (sampled in IDLE only)
//               sw_ab   in  target AB select, latched on accept
//               sw_cd   in  target CD select, latched on accept
//               sw_busy out sequence in progress
//               sw_done out one-cycle pulse at end of sequence
//               cntrlAB out registered AB select (0=A, 1=B)
//               cntrlCD out registered CD select (0=C, 1=D)
//               req     in  [1:0] data requests
//               d0, d1  in  [1:0] requester data
//               gnt     out [1:0] one-hot grant pulse
//               di      out [1:0] registered capture data
//               di_vld  out di updated this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int DRAIN_CYC  = DRAIN_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int CW         = CW_DEF
) (
    input  logic       clkAB,
    input  logic       rst,
    input  logic       sw_req,
    input  logic       sw_ab,
    input  logic       sw_cd,
    output logic       sw_busy,
    output logic       sw_done,
    output logic       cntrlAB,
    output logic       cntrlCD,
    input  logic [1:0] req,
    input  logic [1:0] d0,
    input  logic [1:0] d1,
    output logic [1:0] gnt,
    output logic [1:0] di,
    output logic       di_vld
);

    localparam logic [CW-1:0] c_drain_ld  = CW'(DRAIN_CYC - 1);
    localparam logic [CW-1:0] c_settle_ld = CW'(SETTLE_CYC - 1);

    sw_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_tgt_ab;
    logic          r_tgt_cd;
    logic          r_busy;
    logic          r_done;
    logic          r_ab;
    logic          r_cd;
    logic [1:0]    r_gnt;
    logic [1:0]    r_di;
    logic          r_di_vld;

    logic          w_arb_en;
    logic [1:0]    w_gnt;
    logic          w_ptr;
    logic          w_pick1;

    // A pending switch request takes the IDLE cycle away from arbitration.
    assign w_arb_en = (r_state == IDLE) && !sw_req;

    rr_arb2 u_arb (
        .clkAB  (clkAB),
        .rst    (rst),
        .req    (req),
        .enable (w_arb_en),
        .gnt    (w_gnt),
        .ptr    (w_ptr)
    );

    // Data select follows the same tie-break the arbiter applies from its
    // pointer; only consulted when a grant is actually issued.
    assign w_pick1 = (req == 2'b10) || ((req == 2'b11) && w_ptr);

    always_ff @(posedge clkAB) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_tgt_ab <= 1'b0;
            r_tgt_cd <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ab     <= 1'b0;
            r_cd     <= 1'b0;
            r_gnt    <= 2'b00;
            r_di     <= 2'b00;
            r_di_vld <= 1'b0;
        end else begin
            r_gnt    <= w_gnt;
            r_di_vld <= |w_gnt;
            if (|w_gnt) begin
                r_di <= w_pick1 ? d1 : d0;
            end

            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sw_req) begin
                        r_tgt_ab <= sw_ab;
                        r_tgt_cd <= sw_cd;
                        r_busy   <= 1'b1;
                        if ((sw_ab == r_ab) && (sw_cd == r_cd)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                            r_cnt   <= c_drain_ld;
                        end
                    end
                end
                DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state <= SWITCH;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                SWITCH: begin
                    r_ab    <= r_tgt_ab;
                    r_cd    <= r_tgt_cd;
                    r_cnt   <= c_settle_ld;
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sw_busy = r_busy;
    assign sw_done = r_done;
    assign cntrlAB = r_ab;
    assign cntrlCD = r_cd;
    assign gnt     = r_gnt;
    assign di      = r_di;
    assign di_vld  = r_di_vld;

endmodule
`default_nettype wire

// File: tb/tb_clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_switch_ctrl
// Description : Self-checking bench for clk_switch_ctrl. Stimulus pushes the
//               expected grants and sw_done events into queues; a monitor
//               pops and compares whenever the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_switch_ctrl;

    logic       clkAB  = 1'b0;
    logic       rst    = 1'b1;
    logic       sw_req = 1'b0;
    logic       sw_ab  = 1'b0;
    logic       sw_cd  = 1'b0;
    logic [1:0] req    = 2'b00;
    logic [1:0] d0     = 2'b00;
    logic [1:0] d1     = 2'b00;
    logic       sw_busy;
    logic       sw_done;
    logic       cntrlAB;
    logic       cntrlCD;
    logic [1:0] gnt;
    logic [1:0] di;
    logic       di_vld;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0] g;
        logic [1:0] d;
    } gexp_t;

    typedef struct packed {
        logic ab;
        logic cd;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];

    clk_switch_ctrl dut (
        .clkAB   (clkAB),
        .rst     (rst),
        .sw_req  (sw_req),
        .sw_ab   (sw_ab),
        .sw_cd   (sw_cd),
        .sw_busy (sw_busy),
        .sw_done (sw_done),
        .cntrlAB (cntrlAB),
        .cntrlCD (cntrlCD),
        .req     (req),
        .d0      (d0),
        .d1      (d1),
        .gnt     (gnt),
        .di      (di),
        .di_vld  (di_vld)
    );

    always #5 clkAB = ~clkAB;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkAB);
            #1;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clkAB) begin
        if (di_vld === 1'b1 || (gnt !== 2'b00 && gnt !== 2'bxx)) begin
            if (gq.size() == 0) begin
                chk("grant_unexpected", 8'(gnt), 8'h0);
            end else begin
                gexp_t e;
                e = gq.pop_front();
                chk("grant_gnt", 8'(gnt), 8'(e.g));
                chk("grant_di", 8'(di), 8'(e.d));
                chk("grant_vld", 8'(di_vld), 8'h1);
            end
        end
        if (sw_done === 1'b1) begin
            if (dq.size() == 0) begin
                chk("done_unexpected", 8'(sw_done), 8'h0);
            end else begin
                dexp_t e;
                e = dq.pop_front();
                chk("done_sel", 8'({cntrlAB, cntrlCD}), 8'({e.ab, e.cd}));
                chk("done_busy", 8'(sw_busy), 8'h1);
            end
        end
    end

    initial begin
        int nb;
        int nd;

        // Reset and idle
        tick(3);
        rst = 1'b0;
        chk("rst_busy", 8'(sw_busy), 8'h0);
        chk("rst_done", 8'(sw_done), 8'h0);
        chk("rst_sel", 8'({cntrlAB, cntrlCD}), 8'h0);
        chk("rst_gnt", 8'(gnt), 8'h0);
        chk("rst_di", 8'(di), 8'h0);
        chk("rst_vld", 8'(di_vld), 8'h0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("idle_busy", 8'(sw_busy), 8'h0);
        end

        // Single request, one cycle
        d0  = 2'b10;
        req = 2'b01;
        gq.push_back('{g: 2'b01, d: 2'b10});
        tick(1);
        req = 2'b00;
        tick(3);

        // Both requesting from a fresh pointer: alternate 0,1,0,1
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        d0  = 2'b01;
        d1  = 2'b11;
        req = 2'b11;
        gq.push_back('{g: 2'b01, d: 2'b01});
        gq.push_back('{g: 2'b10, d: 2'b11});
        gq.push_back('{g: 2'b01, d: 2'b01});
        gq.push_back('{g: 2'b10, d: 2'b11});
        tick(4);
        req = 2'b00;
        tick(3);

        // Full switch to B/D with requests pending throughout
        dq.push_back('{ab: 1'b1, cd: 1'b1});
        sw_ab  = 1'b1;
        sw_cd  = 1'b1;
        sw_req = 1'b1;
        req    = 2'b11;
        tick(1);
        sw_req = 1'b0;
        nb = 0;
        for (int k = 0; k < 10; k++) begin
            nb += int'(sw_busy);
            if (k == 2) chk("sel_before_edge3", 8'({cntrlAB, cntrlCD}), 8'h0);
            if (k == 3) chk("sel_after_edge3", 8'({cntrlAB, cntrlCD}), 8'h3);
            if (k == 6) chk("done_before_edge7", 8'(sw_done), 8'h0);
            if (k == 7) begin
                chk("done_after_edge7", 8'(sw_done), 8'h1);
                req = 2'b00;
            end
            tick(1);
        end
        chk("busy_cycles", 8'(nb), 8'd8);

        // No-op switch: targets already selected
        dq.push_back('{ab: 1'b1, cd: 1'b1});
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        nb = 0;
        for (int k = 0; k < 4; k++) begin
            nb += int'(sw_busy);
            tick(1);
        end
        chk("noop_busy_cycles", 8'(nb), 8'd1);
        chk("noop_sel", 8'({cntrlAB, cntrlCD}), 8'h3);

        // Switch and request in the same cycle: switch wins
        d1 = 2'b01;
        dq.push_back('{ab: 1'b1, cd: 1'b1});
        gq.push_back('{g: 2'b10, d: 2'b01});
        sw_req = 1'b1;
        req    = 2'b10;
        tick(1);
        sw_req = 1'b0;
        chk("sw_wins_gnt", 8'(gnt), 8'h0);
        tick(2);
        req = 2'b00;
        tick(3);

        // Switch back to A/C; a second pulse while busy is ignored
        dq.push_back('{ab: 1'b0, cd: 1'b0});
        sw_ab  = 1'b0;
        sw_cd  = 1'b0;
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        tick(1);
        sw_req = 1'b1;
        sw_ab  = 1'b1;
        tick(1);
        sw_req = 1'b0;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            nd += int'(sw_done);
            tick(1);
        end
        chk("done_count", 8'(nd), 8'd1);
        chk("sel_back_ac", 8'({cntrlAB, cntrlCD}), 8'h0);

        // Move pointer to favour requester 1
        d0  = 2'b11;
        req = 2'b01;
        gq.push_back('{g: 2'b01, d: 2'b11});
        tick(1);
        req = 2'b00;
        tick(2);

        // Reset during SETTLE aborts to reset values
        sw_ab  = 1'b1;
        sw_cd  = 1'b1;
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        tick(4);
        chk("settle_sel_changed", 8'({cntrlAB, cntrlCD}), 8'h3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("abort_sel", 8'({cntrlAB, cntrlCD}), 8'h0);
        chk("abort_busy", 8'(sw_busy), 8'h0);
        chk("abort_done", 8'(sw_done), 8'h0);
        chk("abort_gnt", 8'(gnt), 8'h0);

        // Pointer back at requester 0 after reset
        d0  = 2'b10;
        d1  = 2'b01;
        req = 2'b11;
        gq.push_back('{g: 2'b01, d: 2'b10});
        tick(1);
        req = 2'b00;
        tick(10);

        chk("grant_queue_left", 8'(gq.size()), 8'h0);
        chk("done_queue_left", 8'(dq.size()), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
